// File: rtl/sd_sector_arbiter.sv
// sd_sector_arbiter
// Shares the SD SPI sector engine between two requesters. Arbitration is
// round-robin. Each multi-sector job is broken into single-sector start pulses
// with an auto-incrementing sector address. Every job is gated on sd_init_done.
// The one-hot grant lets the top level steer the data paths to the current owner.
//
// Optional feature macro: SD_ARB_TIMEOUT_EN
//   When defined, a watchdog aborts the job if the busy handshake stalls for
//   TIMEOUT cycles in WAIT_BUSY or WAIT_DONE. When undefined, there is no
//   counter, and the arbiter waits on busy indefinitely.
module sd_sector_arbiter #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 4096
) (
    input  logic                 clk_sd,
    input  logic                 reset_n,
    input  logic                 sd_init_done,
    input  logic [1:0]           req_valid,
    input  logic [1:0]           req_wr,
    input  logic [63:0]          req_addr,
    input  logic [2*CNT_W-1:0]   req_cnt,
    output logic [1:0]           req_ack,
    output logic [1:0]           req_done,
    output logic [1:0]           req_err,
    output logic [1:0]           grant,
    output logic                 wr_start_en,
    output logic [31:0]          wr_sec_addr,
    input  logic                 wr_busy,
    output logic                 rd_start_en,
    output logic [31:0]          rd_sec_addr,
    input  logic                 rd_busy
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_WAIT_BUSY = 3'd2;
    localparam logic [2:0] S_WAIT_DONE = 3'd3;
    localparam logic [2:0] S_DONE      = 3'd4;

    logic [2:0]       state_reg, state_next;
    logic [1:0]       grant_reg, ack_reg, done_reg, err_reg;
    logic             owner_reg, last_grant_reg, wr_reg;
    logic [31:0]      cur_addr_reg, wr_sec_addr_reg, rd_sec_addr_reg;
    logic [CNT_W-1:0] remaining_reg;

    logic [31:0]      addr_arr [2];
    logic [CNT_W-1:0] cnt_arr  [2];

    logic             pick_valid, pick_idx;
    logic [1:0]       pick_onehot;
    logic             sel_busy, last_sector, abort, timeout_hit;
    logic [31:0]      next_addr;

    // Split the flat request buses into per-requester fields
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_unpack
            assign addr_arr[gi] = req_addr[32*gi +: 32];
            assign cnt_arr[gi]  = req_cnt[CNT_W*gi +: CNT_W];
        end
    endgenerate

    // Round-robin pick: a lone requester wins; on a tie the one not served last wins
    always_comb begin
        pick_valid  = sd_init_done && (req_valid != 2'b00);
        pick_idx    = (req_valid == 2'b11) ? ~last_grant_reg : req_valid[1];
        pick_onehot = pick_idx ? 2'b10 : 2'b01;
    end

    assign sel_busy    = wr_reg ? wr_busy : rd_busy;
    assign last_sector = (remaining_reg == CNT_W'(1));
    assign next_addr   = cur_addr_reg + 32'd1;

`ifdef SD_ARB_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    logic [TMR_W-1:0] timer_reg;
    logic             waiting;

    assign waiting     = (state_reg == S_WAIT_BUSY) || (state_reg == S_WAIT_DONE);
    assign timeout_hit = waiting && (timer_reg == TMR_W'(TIMEOUT - 1));

    // Busy-phase watchdog: restarts on every state change, counts while waiting
    always_ff @(posedge clk_sd) begin
        if (!reset_n) begin
            timer_reg <= '0;
        end else if (state_next != state_reg) begin
            timer_reg <= '0;
        end else if (waiting) begin
            timer_reg <= timer_reg + TMR_W'(1);
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Next-state logic; losing the card or a stalled handshake aborts any active job
    always_comb begin
        state_next = state_reg;
        abort      = 1'b0;
        case (state_reg)
            S_IDLE:      if (pick_valid) state_next = (cnt_arr[pick_idx] == '0) ? S_DONE : S_START;
            S_START:     state_next = S_WAIT_BUSY;
            S_WAIT_BUSY: if (sel_busy) state_next = S_WAIT_DONE;
            S_WAIT_DONE: if (!sel_busy) state_next = last_sector ? S_DONE : S_START;
            S_DONE:      state_next = S_IDLE;
            default:     state_next = S_IDLE;
        endcase
        if ((state_reg != S_IDLE) && (!sd_init_done || timeout_hit)) begin
            abort      = 1'b1;
            state_next = S_IDLE;
        end
    end

    // Job latch, sector sequencing and handshake pulses
    always_ff @(posedge clk_sd) begin
        if (!reset_n) begin
            state_reg       <= S_IDLE;
            grant_reg       <= '0;
            ack_reg         <= '0;
            done_reg        <= '0;
            err_reg         <= '0;
            owner_reg       <= 1'b0;
            last_grant_reg  <= 1'b1;
            wr_reg          <= 1'b0;
            cur_addr_reg    <= '0;
            wr_sec_addr_reg <= '0;
            rd_sec_addr_reg <= '0;
            remaining_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ack_reg   <= '0;
            done_reg  <= '0;
            err_reg   <= '0;
            if (abort) begin
                done_reg       <= grant_reg;
                err_reg        <= grant_reg;
                grant_reg      <= '0;
                last_grant_reg <= owner_reg;
            end else begin
                case (state_reg)
                    S_IDLE: begin
                        if (pick_valid) begin
                            owner_reg     <= pick_idx;
                            grant_reg     <= pick_onehot;
                            ack_reg       <= pick_onehot;
                            wr_reg        <= req_wr[pick_idx];
                            cur_addr_reg  <= addr_arr[pick_idx];
                            remaining_reg <= cnt_arr[pick_idx];
                            // Present the first address alongside the first start pulse
                            if (cnt_arr[pick_idx] != '0) begin
                                if (req_wr[pick_idx]) wr_sec_addr_reg <= addr_arr[pick_idx];
                                else                  rd_sec_addr_reg <= addr_arr[pick_idx];
                            end
                        end else begin
                            // Grant is held through the done cycle, dropped here
                            grant_reg <= '0;
                        end
                    end
                    S_WAIT_DONE: begin
                        if (!sel_busy) begin
                            remaining_reg <= remaining_reg - CNT_W'(1);
                            if (!last_sector) begin
                                cur_addr_reg <= next_addr;
                                if (wr_reg) wr_sec_addr_reg <= next_addr;
                                else        rd_sec_addr_reg <= next_addr;
                            end
                        end
                    end
                    S_DONE: begin
                        done_reg       <= grant_reg;
                        last_grant_reg <= owner_reg;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign req_ack     = ack_reg;
    assign req_done    = done_reg;
    assign req_err     = err_reg;
    assign grant       = grant_reg;
    assign wr_start_en = (state_reg == S_START) && wr_reg && sd_init_done;
    assign rd_start_en = (state_reg == S_START) && !wr_reg && sd_init_done;
    assign wr_sec_addr = wr_sec_addr_reg;
    assign rd_sec_addr = rd_sec_addr_reg;

endmodule

// File: tb/tb_sd_sector_arbiter.sv
// Testbench for sd_sector_arbiter: directed jobs, scoreboard queue of expected
// ack/start/done events, checked by an independent negedge monitor.
module tb_sd_sector_arbiter;

    localparam int CNT_W      = 16;
    localparam int TB_TIMEOUT = 16;

    localparam int K_ACK  = 0;
    localparam int K_WR   = 1;
    localparam int K_RD   = 2;
    localparam int K_DONE = 3;

    localparam int R_NONE  = 0;
    localparam int R_MARK  = 1;
    localparam int R_ACK   = 2;
    localparam int R_START = 3;
    localparam int R_FALL  = 4;

    logic               clk_sd;
    logic               reset_n;
    logic               sd_init_done;
    logic [1:0]         req_valid;
    logic [1:0]         req_wr;
    logic [63:0]        req_addr;
    logic [2*CNT_W-1:0] req_cnt;
    logic [1:0]         req_ack, req_done, req_err, grant;
    logic               wr_start_en, rd_start_en;
    logic [31:0]        wr_sec_addr, rd_sec_addr;
    logic               wr_busy, rd_busy;

    typedef struct {
        int          kind;
        logic [31:0] val;
        int          lat;
        int          ref_sel;
    } exp_t;

    exp_t exp_q[$];

    int checks   = 0;
    int failures = 0;
    int cyc            = 0;
    int mark_cyc       = 0;
    int fall_cyc       = 0;
    int last_ack_cyc   = 0;
    int last_start_cyc = 0;
    logic busy_stuck   = 1'b0;
    int   busy_len     = 5;

    sd_sector_arbiter #(.CNT_W(CNT_W), .TIMEOUT(TB_TIMEOUT)) dut (
        .clk_sd       (clk_sd),
        .reset_n      (reset_n),
        .sd_init_done (sd_init_done),
        .req_valid    (req_valid),
        .req_wr       (req_wr),
        .req_addr     (req_addr),
        .req_cnt      (req_cnt),
        .req_ack      (req_ack),
        .req_done     (req_done),
        .req_err      (req_err),
        .grant        (grant),
        .wr_start_en  (wr_start_en),
        .wr_sec_addr  (wr_sec_addr),
        .wr_busy      (wr_busy),
        .rd_start_en  (rd_start_en),
        .rd_sec_addr  (rd_sec_addr),
        .rd_busy      (rd_busy)
    );

    initial clk_sd = 1'b0;
    always #5 clk_sd = ~clk_sd;

    always @(posedge clk_sd) cyc <= cyc + 1;

    function automatic logic [31:0] ev_ack(input logic [1:0] g, input logic [1:0] a);
        return {28'd0, g, a};
    endfunction

    function automatic logic [31:0] ev_done(input logic [1:0] g, input logic [1:0] e, input logic [1:0] d);
        return {26'd0, g, e, d};
    endfunction

    task automatic push_exp(input int kind, input logic [31:0] val, input int lat, input int ref_sel);
        exp_t e;
        e.kind    = kind;
        e.val     = val;
        e.lat     = lat;
        e.ref_sel = ref_sel;
        exp_q.push_back(e);
    endtask

    // Pop the oldest expected event and compare it with what the DUT just showed
    task automatic check_ev(input int kind, input logic [31:0] act, input string name);
        exp_t e;
        int   ref_cyc;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s: unexpected event val=%h at cyc %0d, required no event", name, act, cyc);
            return;
        end
        e = exp_q.pop_front();
        case (e.ref_sel)
            R_MARK:  ref_cyc = mark_cyc;
            R_ACK:   ref_cyc = last_ack_cyc;
            R_START: ref_cyc = last_start_cyc;
            R_FALL:  ref_cyc = fall_cyc;
            default: ref_cyc = 0;
        endcase
        if (e.kind != kind || e.val != act) begin
            failures++;
            $display("FAIL %s: got kind=%0d val=%h, required kind=%0d val=%h", name, kind, act, e.kind, e.val);
        end else if (e.ref_sel != R_NONE && (cyc - ref_cyc) != e.lat) begin
            failures++;
            $display("FAIL %s latency: got %0d cycles, required %0d", name, cyc - ref_cyc, e.lat);
        end else begin
            $display("txn %s val=%h cyc=%0d ok", name, act, cyc);
        end
    endtask

    // Monitor: every visible DUT event is matched against the scoreboard
    always @(negedge clk_sd) begin
        if (wr_start_en && rd_start_en) begin
            checks++;
            failures++;
            $display("FAIL dual_start: wr and rd start both high, required at most one");
        end
        if (req_ack != 2'b00) begin
            check_ev(K_ACK, ev_ack(grant, req_ack), "ack");
            last_ack_cyc = cyc;
        end
        if (wr_start_en) begin
            check_ev(K_WR, wr_sec_addr, "wr_start");
            last_start_cyc = cyc;
        end
        if (rd_start_en) begin
            check_ev(K_RD, rd_sec_addr, "rd_start");
            last_start_cyc = cyc;
        end
        if (req_done != 2'b00 || req_err != 2'b00) begin
            check_ev(K_DONE, ev_done(grant, req_err, req_done), "done");
        end
    end

    // Sector engine model: busy rises the cycle after a start, stays high busy_len cycles
    initial begin
        logic is_wr;
        wr_busy = 1'b0;
        rd_busy = 1'b0;
        forever begin
            @(negedge clk_sd);
            if ((wr_start_en || rd_start_en) && !busy_stuck) begin
                is_wr = wr_start_en;
                @(posedge clk_sd);
                #1;
                if (is_wr) wr_busy = 1'b1;
                else       rd_busy = 1'b1;
                repeat (busy_len) @(posedge clk_sd);
                #1;
                wr_busy  = 1'b0;
                rd_busy  = 1'b0;
                fall_cyc = cyc;
            end
        end
    end

    task automatic set_req(input int idx, input logic wr, input logic [31:0] addr, input logic [CNT_W-1:0] cnt);
        req_wr[idx]                 = wr;
        req_addr[32*idx +: 32]      = addr;
        req_cnt[CNT_W*idx +: CNT_W] = cnt;
    endtask

    task automatic do_reset();
        @(negedge clk_sd);
        reset_n = 1'b0;
        repeat (3) @(negedge clk_sd);
        checks++;
        if ({req_ack, req_done, req_err, grant, wr_start_en, rd_start_en} != 10'd0) begin
            failures++;
            $display("FAIL reset_ctrl: got %b, required 0", {req_ack, req_done, req_err, grant, wr_start_en, rd_start_en});
        end
        checks++;
        if (wr_sec_addr != 32'd0) begin
            failures++;
            $display("FAIL reset_wr_addr: got %h, required 00000000", wr_sec_addr);
        end
        checks++;
        if (rd_sec_addr != 32'd0) begin
            failures++;
            $display("FAIL reset_rd_addr: got %h, required 00000000", rd_sec_addr);
        end
        reset_n = 1'b1;
    endtask

    // Wait (bounded) for an ack in mask, then drop the request bits in drop
    task automatic wait_ack(input logic [1:0] mask, input logic [1:0] drop, input int max_cyc, input string name);
        int n = 0;
        while ((req_ack & mask) == 2'b00 && n < max_cyc) begin
            @(negedge clk_sd);
            n++;
        end
        if ((req_ack & mask) == 2'b00) begin
            checks++;
            failures++;
            $display("FAIL %s: no ack within %0d cycles, required ack %b", name, max_cyc, mask);
        end
        req_valid = req_valid & ~drop;
    endtask

    task automatic wait_next_start(input int max_cyc, input string name);
        int n = 0;
        do begin
            @(negedge clk_sd);
            n++;
        end while (!(wr_start_en || rd_start_en) && n < max_cyc);
        if (!(wr_start_en || rd_start_en)) begin
            checks++;
            failures++;
            $display("FAIL %s: no start within %0d cycles, required a start pulse", name, max_cyc);
        end
    endtask

    // Wait until every expected event was seen, then allow a few idle cycles for strays
    task automatic drain(input int max_cyc, input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < max_cyc) begin
            @(negedge clk_sd);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s: %0d events still pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (4) @(negedge clk_sd);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: run did not complete in time, required completion");
        $fatal(1, "watchdog");
    end

    // Directed stimulus
    initial begin
        reset_n      = 1'b0;
        sd_init_done = 1'b0;
        req_valid    = 2'b00;
        req_wr       = 2'b00;
        req_addr     = '0;
        req_cnt      = '0;
        do_reset();

        // Request held while the card is not ready: no ack; ack 1 cycle after init_done rises
        set_req(0, 1'b0, 32'h0000_0005, 16'd1);
        req_valid = 2'b01;
        repeat (20) @(posedge clk_sd);
        push_exp(K_ACK,  ev_ack(2'b01, 2'b01), 1, R_MARK);
        push_exp(K_RD,   32'h0000_0005, 0, R_NONE);
        push_exp(K_DONE, ev_done(2'b01, 2'b00, 2'b01), 0, R_NONE);
        #1;
        sd_init_done = 1'b1;
        mark_cyc     = cyc;
        wait_ack(2'b01, 2'b01, 10, "t1_ack");
        drain(100, "t1_drain");

        // Three-sector write: addresses 0x100..0x102, done 2 cycles after busy is driven low
        set_req(0, 1'b1, 32'h0000_0100, 16'd3);
        push_exp(K_ACK,  ev_ack(2'b01, 2'b01), 0, R_NONE);
        push_exp(K_WR,   32'h0000_0100, 0, R_NONE);
        push_exp(K_WR,   32'h0000_0101, 0, R_NONE);
        push_exp(K_WR,   32'h0000_0102, 0, R_NONE);
        push_exp(K_DONE, ev_done(2'b01, 2'b00, 2'b01), 2, R_FALL);
        req_valid = 2'b01;
        wait_ack(2'b01, 2'b01, 10, "t2_ack");
        drain(200, "t2_drain");

        // Both requesters held after reset: served 0, 1, 0
        do_reset();
        set_req(0, 1'b1, 32'h0000_0010, 16'd1);
        set_req(1, 1'b0, 32'h0000_0020, 16'd1);
        push_exp(K_ACK,  ev_ack(2'b01, 2'b01), 0, R_NONE);
        push_exp(K_WR,   32'h0000_0010, 0, R_NONE);
        push_exp(K_DONE, ev_done(2'b01, 2'b00, 2'b01), 0, R_NONE);
        push_exp(K_ACK,  ev_ack(2'b10, 2'b10), 0, R_NONE);
        push_exp(K_RD,   32'h0000_0020, 0, R_NONE);
        push_exp(K_DONE, ev_done(2'b10, 2'b00, 2'b10), 0, R_NONE);
        push_exp(K_ACK,  ev_ack(2'b01, 2'b01), 0, R_NONE);
        push_exp(K_WR,   32'h0000_0010, 0, R_NONE);
        push_exp(K_DONE, ev_done(2'b01, 2'b00, 2'b01), 0, R_NONE);
        req_valid = 2'b11;
        wait_ack(2'b01, 2'b00, 10, "t3_ack0");
        wait_ack(2'b10, 2'b00, 50, "t3_ack1");
        wait_ack(2'b01, 2'b11, 50, "t3_ack2");
        drain(200, "t3_drain");

        // Read across the 32-bit address wrap
        set_req(1, 1'b0, 32'hFFFF_FFFF, 16'd2);
        push_exp(K_ACK,  ev_ack(2'b10, 2'b10), 0, R_NONE);
        push_exp(K_RD,   32'hFFFF_FFFF, 0, R_NONE);
        push_exp(K_RD,   32'h0000_0000, 0, R_NONE);
        push_exp(K_DONE, ev_done(2'b10, 2'b00, 2'b10), 0, R_NONE);
        req_valid = 2'b10;
        wait_ack(2'b10, 2'b10, 10, "t4_ack");
        drain(200, "t4_drain");

        // Card lost during WAIT_DONE of sector 2 of 4: done+err together, grant already 00
        set_req(1, 1'b1, 32'h0000_0200, 16'd4);
        push_exp(K_ACK,  ev_ack(2'b10, 2'b10), 0, R_NONE);
        push_exp(K_WR,   32'h0000_0200, 0, R_NONE);
        push_exp(K_WR,   32'h0000_0201, 0, R_NONE);
        push_exp(K_DONE, ev_done(2'b00, 2'b10, 2'b10), 1, R_MARK);
        req_valid = 2'b10;
        wait_ack(2'b10, 2'b10, 10, "t5_ack");
        wait_next_start(50, "t5_start2");
        repeat (3) @(posedge clk_sd);
        #1;
        sd_init_done = 1'b0;
        mark_cyc     = cyc;
        drain(50, "t5_drain");
        repeat (8) @(negedge clk_sd);
        sd_init_done = 1'b1;

        // Zero-length job: ack, done the next cycle, no start pulse
        set_req(0, 1'b0, 32'h0000_0077, 16'd0);
        push_exp(K_ACK,  ev_ack(2'b01, 2'b01), 0, R_NONE);
        push_exp(K_DONE, ev_done(2'b01, 2'b00, 2'b01), 1, R_ACK);
        req_valid = 2'b01;
        wait_ack(2'b01, 2'b01, 10, "t6_ack");
        drain(50, "t6_drain");

`ifdef SD_ARB_TIMEOUT_EN
        // Busy never rises: abort exactly TIMEOUT cycles after entering WAIT_BUSY
        busy_stuck = 1'b1;
        set_req(0, 1'b1, 32'h0000_0040, 16'd2);
        push_exp(K_ACK,  ev_ack(2'b01, 2'b01), 0, R_NONE);
        push_exp(K_WR,   32'h0000_0040, 0, R_NONE);
        push_exp(K_DONE, ev_done(2'b00, 2'b01, 2'b01), TB_TIMEOUT + 1, R_START);
        req_valid = 2'b01;
        wait_ack(2'b01, 2'b01, 10, "t7_ack");
        drain(100, "t7_drain");
        busy_stuck = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
